// File: rtl/unidad_busqueda.sv
// unidad_busqueda: instruction fetch stage feeding the control unit.
//
// Holds the program counter, fetches 32-bit words through a req/ack
// instruction-memory handshake and presents the latched instruction plus its
// decoded op/f3/f7 fields. Once an instruction is consumed (not stalled), the
// next PC is either pc+4 or the branch target chosen by the control unit.
//
// Ports:
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   imem_req, imem_addr         fetch request and address (= pc)
//   imem_ack, imem_rdata        memory acceptance and same-cycle instruction word
//   pcSrc, pc_target            branch decision and target from UC / datapath
//   stall                       downstream cannot consume the current instruction
//   inst_valid, instr, op, f3, f7, pc_actual, pc_mas4   delivered instruction
//   error_alin, error_timeout   sticky error flags (cleared only by reset)
//   num_instr                   consumed-instruction counter (CONTADOR_INSTR_EN only)
//
// Optional feature: define CONTADOR_INSTR_EN to add the num_instr output.

module unidad_busqueda #(
  parameter int                   ANCHO_DIR  = 32,
  parameter logic [ANCHO_DIR-1:0] PC_RESET   = '0,
  parameter int                   MAX_ESPERA = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [ANCHO_DIR-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  input  logic                 pcSrc,
  input  logic [ANCHO_DIR-1:0] pc_target,
  input  logic                 stall,
  output logic                 inst_valid,
  output logic [31:0]          instr,
  output logic [6:0]           op,
  output logic [2:0]           f3,
  output logic                 f7,
  output logic [ANCHO_DIR-1:0] pc_actual,
  output logic [ANCHO_DIR-1:0] pc_mas4,
`ifdef CONTADOR_INSTR_EN
  output logic [31:0]          num_instr,
`endif
  output logic                 error_alin,
  output logic                 error_timeout
);

  localparam int CW = $clog2(MAX_ESPERA + 1);

  typedef enum logic [1:0] {
    PEDIR     = 2'd0,
    REINTENTO = 2'd1,
    ENTREGAR  = 2'd2
  } estado_t;

  estado_t              estado_q;
  logic [ANCHO_DIR-1:0] pc_q;
  logic [ANCHO_DIR-1:0] pc_d;
  logic [ANCHO_DIR-1:0] pc_actual_q;
  logic [31:0]          instr_q;
  logic                 valid_q;
  logic [CW-1:0]        cnt_q;
  logic                 err_alin_q;
  logic                 err_to_q;
  logic                 alin_mal_s;
`ifdef CONTADOR_INSTR_EN
  logic [31:0]          num_instr_q;
`endif

  // Next PC after consumption: aligned branch target or sequential pc+4 (wraps).
  always_comb begin
    pc_d       = pc_q + ANCHO_DIR'(32'd4);
    alin_mal_s = 1'b0;
    if (pcSrc) begin
      pc_d       = {pc_target[ANCHO_DIR-1:2], 2'b00};
      alin_mal_s = (pc_target[1:0] != 2'b00);
    end else begin
      pc_d       = pc_q + ANCHO_DIR'(32'd4);
      alin_mal_s = 1'b0;
    end
  end

  // Fetch FSM with all stage state and delivered outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= PEDIR;
      pc_q        <= PC_RESET;
      pc_actual_q <= PC_RESET;
      instr_q     <= 32'd0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      err_alin_q  <= 1'b0;
      err_to_q    <= 1'b0;
`ifdef CONTADOR_INSTR_EN
      num_instr_q <= 32'd0;
`endif
    end else begin
      case (estado_q)
        PEDIR: begin
          if (imem_ack) begin
            instr_q     <= imem_rdata;
            pc_actual_q <= pc_q;
            valid_q     <= 1'b1;
            cnt_q       <= '0;
            estado_q    <= ENTREGAR;
          end else if (cnt_q == CW'(MAX_ESPERA - 1)) begin
            // The request has been up for MAX_ESPERA cycles: drop it for a
            // cycle and ask again for the same address.
            err_to_q <= 1'b1;
            cnt_q    <= '0;
            estado_q <= REINTENTO;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        REINTENTO: begin
          estado_q <= PEDIR;
        end
        ENTREGAR: begin
          // pcSrc/pc_target only matter on the consuming cycle.
          if (!stall) begin
            pc_q     <= pc_d;
            valid_q  <= 1'b0;
            estado_q <= PEDIR;
            if (alin_mal_s) begin
              err_alin_q <= 1'b1;
            end
`ifdef CONTADOR_INSTR_EN
            num_instr_q <= num_instr_q + 32'd1;
`endif
          end
        end
        default: begin
          estado_q <= PEDIR;
          valid_q  <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign imem_req      = (estado_q == PEDIR);
  assign imem_addr     = pc_q;
  assign inst_valid    = valid_q;
  assign instr         = instr_q;
  assign op            = instr_q[6:0];
  assign f3            = instr_q[14:12];
  assign f7            = instr_q[30];
  assign pc_actual     = pc_actual_q;
  assign pc_mas4       = pc_actual_q + ANCHO_DIR'(32'd4);
  assign error_alin    = err_alin_q;
  assign error_timeout = err_to_q;
`ifdef CONTADOR_INSTR_EN
  assign num_instr     = num_instr_q;
`endif

endmodule

// File: tb/tb_unidad_busqueda.sv
module tb_unidad_busqueda;

  localparam logic [31:0] BASE = 32'h40B5_0533;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic        pcSrc;
  logic [31:0] pc_target;
  logic        stall;

  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        inst_valid, inst_valid2;
  logic [31:0] instr, instr2;
  logic [6:0]  op, op2;
  logic [2:0]  f3, f32;
  logic        f7, f72;
  logic [31:0] pc_actual, pc_actual2;
  logic [31:0] pc_mas4, pc_mas42;
  logic        error_alin, error_alin2;
  logic        error_timeout, error_timeout2;
`ifdef CONTADOR_INSTR_EN
  logic [31:0] num_instr, num_instr2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: every word is BASE plus its own address.
  assign imem_rdata  = BASE + imem_addr;
  assign imem_rdata2 = BASE + imem_addr2;

  always #5 clk = ~clk;

  unidad_busqueda #(.ANCHO_DIR(32), .PC_RESET(32'h0), .MAX_ESPERA(15)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pcSrc(pcSrc),
    .pc_target(pc_target), .stall(stall), .inst_valid(inst_valid),
    .instr(instr), .op(op), .f3(f3), .f7(f7), .pc_actual(pc_actual),
    .pc_mas4(pc_mas4),
`ifdef CONTADOR_INSTR_EN
    .num_instr(num_instr),
`endif
    .error_alin(error_alin), .error_timeout(error_timeout)
  );

  unidad_busqueda #(.ANCHO_DIR(32), .PC_RESET(32'hFFFF_FFFC), .MAX_ESPERA(15)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata2), .pcSrc(pcSrc),
    .pc_target(pc_target), .stall(stall), .inst_valid(inst_valid2),
    .instr(instr2), .op(op2), .f3(f32), .f7(f72), .pc_actual(pc_actual2),
    .pc_mas4(pc_mas42),
`ifdef CONTADOR_INSTR_EN
    .num_instr(num_instr2),
`endif
    .error_alin(error_alin2), .error_timeout(error_timeout2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; pcSrc = 1'b0; pc_target = 32'h0; stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b1; pcSrc = 1'b0; pc_target = 32'h0; stall = 1'b0;
    tick();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    n_checks++; if ({error_alin, error_timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_errors: got %b expected 00", {error_alin, error_timeout}); end
    reset = 1'b0; imem_ack = 1'b0;
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL reset_req: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    tick();
  endtask

  task automatic test_sequential();
    imem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if ({inst_valid, pc_actual, instr} !== {1'b1, 32'(4*i), BASE + 32'(4*i)})
        begin n_fail++; $display("FAIL seq_deliver%0d: got %b/%h/%h expected 1/%h/%h", i, inst_valid, pc_actual, instr, 32'(4*i), BASE + 32'(4*i)); end
      if (i == 0) begin
        n_checks++; if ({op, f3, f7} !== {7'h33, 3'd0, 1'b1}) begin n_fail++; $display("FAIL seq_fields: got %h/%h/%b expected 33/0/1", op, f3, f7); end
      end
      tick();
      n_checks++; if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'(4*i + 4)})
        begin n_fail++; $display("FAIL seq_fetch%0d: got %b/%b/%h expected 0/1/%h", i, inst_valid, imem_req, imem_addr, 32'(4*i + 4)); end
    end
  endtask

  task automatic test_branch();
    tick();
    n_checks++; if ({inst_valid, pc_actual, pc_mas4} !== {1'b1, 32'h8, 32'hC}) begin n_fail++; $display("FAIL br_at8: got %b/%h/%h expected 1/00000008/0000000c", inst_valid, pc_actual, pc_mas4); end
    pcSrc = 1'b1; pc_target = 32'h40;
    tick();
    pcSrc = 1'b0; pc_target = 32'h0;
    n_checks++; if ({imem_addr, error_alin} !== {32'h40, 1'b0}) begin n_fail++; $display("FAIL br_target: got %h/%b expected 00000040/0", imem_addr, error_alin); end
    tick();
    n_checks++; if ({pc_actual, pc_mas4, instr} !== {32'h40, 32'h44, BASE + 32'h40}) begin n_fail++; $display("FAIL br_deliver: got %h/%h/%h expected 00000040/00000044/%h", pc_actual, pc_mas4, instr, BASE + 32'h40); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin pcSrc = 1'b1; pc_target = 32'h80; end
      tick();
      n_checks++; if ({inst_valid, imem_req, pc_actual, instr} !== {1'b1, 1'b0, 32'h40, BASE + 32'h40})
        begin n_fail++; $display("FAIL stall_hold%0d: got %b/%b/%h/%h", i, inst_valid, imem_req, pc_actual, instr); end
    end
    stall = 1'b0; pcSrc = 1'b0; pc_target = 32'h0;
    tick();
    n_checks++; if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h44, 1'b0}) begin n_fail++; $display("FAIL stall_resume: got %b/%h/%b expected 1/00000044/0", imem_req, imem_addr, inst_valid); end
  endtask

  task automatic test_timeout();
    int n = 0;
    imem_ack = 1'b0;
    n_checks++; if (error_timeout !== 1'b0) begin n_fail++; $display("FAIL to_pre: got %b expected 0", error_timeout); end
    while (imem_req && n < 40) begin
      n++;
      tick();
    end
    n_checks++; if (n !== 15) begin n_fail++; $display("FAIL to_cycles: got %0d expected 15", n); end
    n_checks++; if ({imem_req, error_timeout} !== 2'b01) begin n_fail++; $display("FAIL to_retry: got %b/%b expected 0/1", imem_req, error_timeout); end
    tick();
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h44}) begin n_fail++; $display("FAIL to_rereq: got %b/%h expected 1/00000044", imem_req, imem_addr); end
    tick();
    imem_ack = 1'b1;
    tick();
    n_checks++; if ({inst_valid, pc_actual, instr, error_timeout} !== {1'b1, 32'h44, BASE + 32'h44, 1'b1})
      begin n_fail++; $display("FAIL to_deliver: got %b/%h/%h/%b", inst_valid, pc_actual, instr, error_timeout); end
  endtask

  task automatic test_misaligned();
    pcSrc = 1'b1; pc_target = 32'h42;
    tick();
    pcSrc = 1'b0; pc_target = 32'h0;
    n_checks++; if ({imem_addr, error_alin} !== {32'h40, 1'b1}) begin n_fail++; $display("FAIL mis_target: got %h/%b expected 00000040/1", imem_addr, error_alin); end
    tick();
    tick();
    n_checks++; if ({imem_addr, error_alin} !== {32'h44, 1'b1}) begin n_fail++; $display("FAIL mis_sticky: got %h/%b expected 00000044/1", imem_addr, error_alin); end
  endtask

  task automatic test_reset_mid();
    // Currently in PEDIR with ack high; reset must win over the ack.
    reset = 1'b1;
    tick();
    reset = 1'b0; imem_ack = 1'b0;
    n_checks++; if ({inst_valid, imem_addr, error_alin, error_timeout} !== {1'b0, 32'h0, 2'b00})
      begin n_fail++; $display("FAIL rst_mid: got %b/%h/%b/%b expected 0/00000000/0/0", inst_valid, imem_addr, error_alin, error_timeout); end
    tick();
    n_checks++; if ({inst_valid, imem_req} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_nolatch: got %b/%b expected 0/1", inst_valid, imem_req); end
  endtask

  task automatic test_wrap();
    do_reset();
    n_checks++; if (imem_addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_reset: got %h expected fffffffc", imem_addr2); end
    imem_ack = 1'b1;
    tick();
    n_checks++; if ({inst_valid2, pc_actual2, pc_mas42} !== {1'b1, 32'hFFFF_FFFC, 32'h0})
      begin n_fail++; $display("FAIL wrap_deliver: got %b/%h/%h expected 1/fffffffc/00000000", inst_valid2, pc_actual2, pc_mas42); end
    tick();
    n_checks++; if (imem_addr2 !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got %h expected 00000000", imem_addr2); end
  endtask

`ifdef CONTADOR_INSTR_EN
  task automatic test_counter();
    do_reset();
    n_checks++; if (num_instr !== 32'd0) begin n_fail++; $display("FAIL cnt_reset: got %0d expected 0", num_instr); end
    imem_ack = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (num_instr !== 32'd5) begin n_fail++; $display("FAIL cnt_five: got %0d expected 5", num_instr); end
  endtask
`endif

  initial begin
    reset = 1'b1; imem_ack = 1'b0; pcSrc = 1'b0; pc_target = 32'h0; stall = 1'b0;
    tick();
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    test_wrap();
`ifdef CONTADOR_INSTR_EN
    test_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
